// File: rtl/izhikevich_state_update.sv
// izhikevich_state_update
// Integration stage of the Izhikevich neuron core. Holds the membrane
// potential v and recovery variable w, captures the upstream derivatives
// on a timestep tick, commits v += dv / w += dw with saturation, and
// applies the spike reset (v <= c, w <= w + d) on a threshold crossing.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            start one integration step (sampled in IDLE only)
//   dv, dw          step-scaled derivatives from the derivative stages
//   c, d            post-spike v value and w increment (sampled in COMMIT)
//   v, w            registered state, fed back to the derivative stages
//   busy            state is not IDLE
//   done, spike     one-cycle pulses when a step commits / crossed threshold
//   spike_count     saturating spike counter
//   overrun         sticky: tick arrived while busy
//
// state  | meaning
// IDLE   | waiting for tick; v/w stable for the derivative stages
// EVAL   | derivatives settled, capture dv/dw
// COMMIT | write back v/w, pulse done (and spike)

module izhikevich_state_update #(
    parameter int N      = 24,
    parameter int Q      = 8,
    parameter int V_PEAK = 7680,
    parameter int V_INIT = -16640,
    parameter int W_INIT = -3328,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic signed [N-1:0] dv,
    input  logic signed [N-1:0] dw,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] v,
    output logic signed [N-1:0] w,
    output logic                busy,
    output logic                done,
    output logic                spike,
    output logic [CNT_W-1:0]    spike_count,
    output logic                overrun
);

    // Q only sets the interpretation of the raw words; guard against nonsense.
    if ((Q < 0) || (Q >= N)) begin : g_bad_q
        $error("Q must lie in [0, N-1]");
    end

    localparam logic signed [N-1:0] V_PEAK_W = N'(V_PEAK);
    localparam logic signed [N-1:0] V_INIT_W = N'(V_INIT);
    localparam logic signed [N-1:0] W_INIT_W = N'(W_INIT);
    localparam logic signed [N-1:0] S_MAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] S_MIN    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [N-1:0] dv_q, dw_q;
    logic signed [N-1:0] v_sum, w_sum, w_spk;
    logic                spike_hit;

    // One extra bit catches overflow: the top two bits differ only when the
    // true sum fell outside the N-bit range, and the top bit gives the side.
    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1])
            sat_add = s[N] ? S_MIN : S_MAX;
        else
            sat_add = s[N-1:0];
    endfunction

    always_comb begin
        v_sum     = sat_add(v, dv_q);
        w_sum     = sat_add(w, dw_q);
        w_spk     = sat_add(w_sum, d);
        spike_hit = (v_sum >= V_PEAK_W);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = EVAL;
            EVAL:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v           <= V_INIT_W;
            w           <= W_INIT_W;
            dv_q        <= '0;
            dw_q        <= '0;
            done        <= 1'b0;
            spike       <= 1'b0;
            spike_count <= '0;
            overrun     <= 1'b0;
        end else begin
            done  <= 1'b0;
            spike <= 1'b0;
            if (tick && (state != IDLE))
                overrun <= 1'b1;
            if (state == EVAL) begin
                dv_q <= dv;
                dw_q <= dw;
            end
            if (state == COMMIT) begin
                done <= 1'b1;
                if (spike_hit) begin
                    v     <= c;
                    w     <= w_spk;
                    spike <= 1'b1;
                    if (spike_count != '1)
                        spike_count <= spike_count + 1'b1;
                end else begin
                    v <= v_sum;
                    w <= w_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Directed bench for izhikevich_state_update; expected values are
// hand-computed from the fixed-point arithmetic of each step.

module tb_izhikevich_state_update;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic signed [23:0] dv = '0;
    logic signed [23:0] dw = '0;
    logic signed [23:0] c = '0;
    logic signed [23:0] d = '0;
    logic signed [23:0] v;
    logic signed [23:0] w;
    logic               busy;
    logic               done;
    logic               spike;
    logic [15:0]        spike_count;
    logic               overrun;

    int n_checks = 0;
    int n_pass   = 0;

    izhikevich_state_update dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .dv          (dv),
        .dw          (dw),
        .c           (c),
        .d           (d),
        .v           (v),
        .w           (w),
        .busy        (busy),
        .done        (done),
        .spike       (spike),
        .spike_count (spike_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        edge1();
        edge1();
        rst = 1'b0;
    endtask

    // One full step with per-cycle protocol checks, then state checks.
    task automatic step(input string tag, input int dv_i, input int dw_i,
                        input int c_i, input int d_i, input int v_exp,
                        input int w_exp, input int spk_exp);
        dv   = 24'(dv_i);
        dw   = 24'(dw_i);
        c    = 24'(c_i);
        d    = 24'(d_i);
        tick = 1'b1;
        edge1();                                   // E0
        tick = 1'b0;
        chk({tag, ".busy_e0"}, busy, 1);
        chk({tag, ".done_e0"}, done, 0);
        edge1();                                   // E1
        chk({tag, ".busy_e1"}, busy, 1);
        chk({tag, ".done_e1"}, done, 0);
        edge1();                                   // E2
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_e2"}, busy, 0);
        chk({tag, ".spike"}, spike, spk_exp);
        chk({tag, ".v"}, v, v_exp);
        chk({tag, ".w"}, w, w_exp);
        edge1();
        chk({tag, ".done_off"}, done, 0);
        chk({tag, ".spike_off"}, spike, 0);
    endtask

    initial begin
        int exp_done [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        int exp_busy [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
        int exp_ovr  [8] = '{0, 1, 1, 1, 1, 1, 1, 1};

        // reset state
        do_reset();
        chk("rst.v", v, -16640);
        chk("rst.w", w, -3328);
        chk("rst.cnt", spike_count, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.spike", spike, 0);
        chk("rst.overrun", overrun, 0);

        // plain step: -16640+256, -3328-128
        step("plain", 256, -128, -16640, 2048, -16384, -3456, 0);

        // spike from reset: v_sum = 7680 exactly at peak, w = -3328 + 2048
        do_reset();
        step("spike", 24320, 0, -16640, 2048, -16640, -1280, 1);
        chk("spike.cnt", spike_count, 1);

        // positive saturation: -1280 + 8388607 fits, second add clamps
        step("sat1", 0, 24'h7FFFFF, 0, 0, -16640, 8387327, 0);
        step("sat2", 0, 24'h7FFFFF, 0, 0, -16640, 24'h7FFFFF, 0);
        // spike with w already at max: w + d stays clamped
        step("sat_spk", 24320, 0, -16640, 2048, -16640, 24'h7FFFFF, 1);
        chk("sat_spk.cnt", spike_count, 2);

        // negative saturation: max + min = -1, then -1 + min clamps
        step("nsat1", 0, -8388608, 0, 0, -16640, -1, 0);
        step("nsat2", 0, -8388608, 0, 0, -16640, -8388608, 0);

        // one below threshold does not spike
        step("below", 24319, 0, -16640, 2048, 7679, -8388608, 0);
        chk("below.cnt", spike_count, 2);

        // tick held 6 cycles: steps at E0 and E3, overrun sticky
        dv   = -24'sd1;
        dw   = '0;
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            edge1();
            if (i == 5) tick = 1'b0;
            chk($sformatf("b2b.done%0d", i), done, exp_done[i]);
            chk($sformatf("b2b.busy%0d", i), busy, exp_busy[i]);
            chk($sformatf("b2b.ovr%0d", i), overrun, exp_ovr[i]);
        end
        chk("b2b.v", v, 7677);
        chk("b2b.cnt", spike_count, 2);

        // reset mid-step aborts without commit
        do_reset();
        chk("abort.ovr_clr", overrun, 0);
        dv   = 24'sd256;
        dw   = -24'sd128;
        tick = 1'b1;
        edge1();                                   // E0
        tick = 1'b0;
        rst  = 1'b1;
        edge1();                                   // E1 under reset
        rst  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort.done%0d", i), done, 0);
            chk($sformatf("abort.busy%0d", i), busy, 0);
            edge1();
        end
        chk("abort.v", v, -16640);
        chk("abort.w", w, -3328);
        step("after", 256, -128, -16640, 2048, -16384, -3456, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
